// File: rtl/pool_ctrl_pkg.sv
// Shared definitions for the max-pooling frame controller: state encoding,
// counter widths and small width helpers.
package pool_ctrl_pkg;

    // Width of the delivered-frame counter (wraps modulo 2^16).
    localparam int FRAME_CNT_W = 16;

    // Controller states, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } pool_state_t;

    // Column counter width: enough to hold 0..input_width-1, never below 1 bit.
    function automatic int col_cnt_width(input int input_width);
        return (input_width > 1) ? $clog2(input_width) : 1;
    endfunction

    // Wait counter width: must be able to hold the timeout value itself.
    function automatic int wait_cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/maxpool_ctrl.sv
// Frame controller for a column-streaming max-pooling datapath.
// Accepts INPUT_WIDTH columns from upstream and forwards each one to the
// datapath as a shift/compute strobe, then issues one zero-column flush
// strobe, waits for the datapath result strobe and holds the pooled frame
// valid for downstream until it is accepted. A result that never arrives
// raises a sticky timeout flag and abandons the frame.
module maxpool_ctrl
    import pool_ctrl_pkg::*;
#(
    parameter int INPUT_WIDTH    = 40,
    parameter int INPUT_CHANNELS = 8,
    parameter int ACTIV_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [INPUT_CHANNELS*ACTIV_BITS-1:0] s_col,
    output logic                                 dp_valid,
    output logic [INPUT_CHANNELS*ACTIV_BITS-1:0] dp_col,
    input  logic                                 dp_out_valid,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 busy,
    output logic [FRAME_CNT_W-1:0]               frame_count,
    output logic                                 timeout_err
);

    localparam int COL_BITS = INPUT_CHANNELS * ACTIV_BITS;
    localparam int COL_W    = col_cnt_width(INPUT_WIDTH);
    localparam int WAIT_W   = wait_cnt_width(TIMEOUT_CYCLES);

    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(INPUT_WIDTH - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

    pool_state_t            state_reg, state_next;
    logic [COL_W-1:0]       col_cnt_reg, col_cnt_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [WAIT_W-1:0]      wait_cnt_inc;
    logic [FRAME_CNT_W-1:0] frame_count_reg, frame_count_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic                   m_valid_reg;

    assign wait_cnt_inc = wait_cnt_reg + 1'b1;

    // State and counter registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            col_cnt_reg     <= '0;
            wait_cnt_reg    <= '0;
            frame_count_reg <= '0;
            timeout_err_reg <= 1'b0;
            m_valid_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            col_cnt_reg     <= col_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            frame_count_reg <= frame_count_next;
            timeout_err_reg <= timeout_err_next;
            // m_valid comes straight from a flop so downstream sees no decode glitches.
            m_valid_reg     <= (state_next == ST_OUT);
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_next       = state_reg;
        col_cnt_next     = col_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        frame_count_next = frame_count_reg;
        timeout_err_next = timeout_err_reg;

        case (state_reg)
            ST_IDLE: begin
                col_cnt_next  = '0;
                wait_cnt_next = '0;
                if (en) begin
                    state_next = ST_LOAD;
                end
            end

            // Every accepted column advances the count; the last one ends loading.
            ST_LOAD: begin
                if (s_valid) begin
                    if (col_cnt_reg == LAST_COL) begin
                        col_cnt_next = '0;
                        state_next   = ST_FLUSH;
                    end else begin
                        col_cnt_next = col_cnt_reg + 1'b1;
                    end
                end
            end

            // Single flush strobe pushes the last real column through the window.
            ST_FLUSH: begin
                wait_cnt_next = '0;
                state_next    = ST_WAIT;
            end

            // Result strobe wins over the timeout on the same cycle.
            ST_WAIT: begin
                if (dp_out_valid) begin
                    wait_cnt_next = '0;
                    state_next    = ST_OUT;
                end else if (wait_cnt_inc == TIMEOUT_VAL) begin
                    wait_cnt_next    = '0;
                    timeout_err_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end

            // en only decides whether another frame follows; it never aborts this one.
            ST_OUT: begin
                if (m_ready) begin
                    frame_count_next = frame_count_reg + 1'b1;
                    state_next       = en ? ST_LOAD : ST_IDLE;
                end
            end

            default: begin
                state_next    = ST_IDLE;
                col_cnt_next  = '0;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Per-state datapath and upstream handshake outputs.
    always_comb begin
        s_ready  = 1'b0;
        dp_valid = 1'b0;
        dp_col   = '0;
        busy     = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                s_ready  = 1'b1;
                dp_valid = s_valid;
                dp_col   = s_col;
            end
            ST_FLUSH: begin
                dp_valid = 1'b1;
                dp_col   = {COL_BITS{1'b0}};
            end
            ST_WAIT: begin
                dp_valid = 1'b0;
            end
            ST_OUT: begin
                // No strobe here: the datapath output must hold still while offered.
                dp_valid = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign m_valid     = m_valid_reg;
    assign frame_count = frame_count_reg;
    assign timeout_err = timeout_err_reg;

endmodule
